layer_priority_mux: RTL and testbench



---
 rtl/layer_priority_mux_pkg.sv | 14 +
 rtl/layer_priority_mux_if.sv | 31 +++
 rtl/layer_priority_mux_encoder.sv | 22 ++
 rtl/layer_priority_mux.sv | 69 ++++++
 tb/tb_layer_priority_mux.sv | 124 ++++++++++++
 5 files changed

// File: rtl/layer_priority_mux_pkg.sv
// Shared defaults and helpers for the VGA layer priority mux.
package layer_mux_pkg;

  localparam int unsigned NUM_LAYERS_DEF = 4;
  localparam int unsigned RGB_W_DEF      = 8;
  localparam logic [7:0]  BG_COLOR_DEF   = 8'hFF;
  localparam int unsigned CNT_W_DEF      = 16;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_ge2(input logic [15:0] vec);
    return (vec & (vec - 16'd1)) != '0;
  endfunction

endpackage

// File: rtl/layer_priority_mux_if.sv
// Layer inputs and registered mux/collision outputs for layer_priority_mux.
interface layer_priority_mux_if #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned RGB_W      = 8,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [NUM_LAYERS-1:0]       drawReq;
  logic [NUM_LAYERS*RGB_W-1:0] layersRGB;
  logic [NUM_LAYERS-1:0]       layerEnable;
  logic                        startOfFrame;
  logic                        outDrawingRequest;
  logic [RGB_W-1:0]            outRGB;
  logic [IDX_W-1:0]            outLayerIdx;
  logic                        collisionPulse;
  logic [NUM_LAYERS-1:0]       frameCollisions;
  logic [CNT_W-1:0]            frameCollisionCount;

  modport master (
    output drawReq, layersRGB, layerEnable, startOfFrame,
    input  outDrawingRequest, outRGB, outLayerIdx, collisionPulse,
           frameCollisions, frameCollisionCount
  );

  modport slave (
    input  drawReq, layersRGB, layerEnable, startOfFrame,
    output outDrawingRequest, outRGB, outLayerIdx, collisionPulse,
           frameCollisions, frameCollisionCount
  );
endinterface

// File: rtl/layer_priority_mux_encoder.sv
// Combinational lowest-set-bit encoder; bit 0 has highest priority.
module lowest_set_encoder #(
  parameter int unsigned NUM_LAYERS = 4,
  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0] req,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (req[i] && !valid) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_priority_mux.sv
// N-layer priority mux with registered RGB output and per-frame collision stats.
module layer_priority_mux
  import layer_mux_pkg::*;
#(
  parameter int unsigned NUM_LAYERS    = NUM_LAYERS_DEF,
  parameter int unsigned RGB_W         = RGB_W_DEF,
  parameter logic [RGB_W-1:0] BG_COLOR = RGB_W'(BG_COLOR_DEF),
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  layer_priority_mux_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [NUM_LAYERS-1:0] eff;
  logic [IDX_W-1:0]      winIdx;
  logic                  anyReq;
  logic                  collision;
  logic [RGB_W-1:0]      winRGB;
  logic [NUM_LAYERS-1:0] accFlags;
  logic [CNT_W-1:0]      accCount;

  assign eff       = bus.drawReq & bus.layerEnable;
  assign collision = popcount_ge2(16'(eff));

  lowest_set_encoder #(.NUM_LAYERS(NUM_LAYERS)) encoder (
    .req   (eff),
    .idx   (winIdx),
    .valid (anyReq)
  );

  always_comb begin
    winRGB = BG_COLOR;
    if (anyReq)
      winRGB = bus.layersRGB[int'(winIdx)*RGB_W +: RGB_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.outDrawingRequest   <= 1'b0;
      bus.outRGB              <= BG_COLOR;
      bus.outLayerIdx         <= '0;
      bus.collisionPulse      <= 1'b0;
      bus.frameCollisions     <= '0;
      bus.frameCollisionCount <= '0;
      accFlags                <= '0;
      accCount                <= '0;
    end else begin
      bus.outDrawingRequest <= anyReq;
      bus.outRGB            <= winRGB;
      bus.outLayerIdx       <= winIdx;
      bus.collisionPulse    <= collision;
      // The SOF pixel is the first pixel of the new frame, so it seeds the accumulators.
      if (bus.startOfFrame) begin
        bus.frameCollisions     <= accFlags;
        bus.frameCollisionCount <= accCount;
        accFlags                <= collision ? eff : '0;
        accCount                <= collision ? CNT_W'(1) : '0;
      end else if (collision) begin
        accFlags <= accFlags | eff;
        if (accCount != '1)
          accCount <= accCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed-vector bench: a 16-bit-counter and a 4-bit-counter instance share stimulus.
module tb_layer_priority_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  drawReq;
  logic [31:0] layersRGB;
  logic [3:0]  layerEnable;
  logic        startOfFrame;

  int unsigned nVectors     = 0;
  int unsigned nMiscompares = 0;

  always #5 clk = ~clk;

  layer_priority_mux_if #(.NUM_LAYERS(4), .RGB_W(8), .CNT_W(16)) busW ();
  layer_priority_mux_if #(.NUM_LAYERS(4), .RGB_W(8), .CNT_W(4))  busN ();

  assign busW.drawReq      = drawReq;
  assign busW.layersRGB    = layersRGB;
  assign busW.layerEnable  = layerEnable;
  assign busW.startOfFrame = startOfFrame;
  assign busN.drawReq      = drawReq;
  assign busN.layersRGB    = layersRGB;
  assign busN.layerEnable  = layerEnable;
  assign busN.startOfFrame = startOfFrame;

  layer_priority_mux #(.NUM_LAYERS(4), .RGB_W(8), .BG_COLOR(8'hFF), .CNT_W(16)) dutW (
    .clk   (clk),
    .reset (reset),
    .bus   (busW)
  );

  layer_priority_mux #(.NUM_LAYERS(4), .RGB_W(8), .BG_COLOR(8'hFF), .CNT_W(4)) dutN (
    .clk   (clk),
    .reset (reset),
    .bus   (busN)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one pixel, then sample the registered result 1ns after the edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic sof);
    reset        = rst;
    drawReq      = req;
    startOfFrame = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic checkPixel(input string tag, input logic [7:0] rgb, input logic draw,
                            input logic [1:0] idx, input logic coll);
    checkVal({tag, ".rgb"},  32'(busW.outRGB), 32'(rgb));
    checkVal({tag, ".draw"}, 32'(busW.outDrawingRequest), 32'(draw));
    checkVal({tag, ".idx"},  32'(busW.outLayerIdx), 32'(idx));
    checkVal({tag, ".coll"}, 32'(busW.collisionPulse), 32'(coll));
  endtask

  task automatic checkFrame(input string tag, input logic [3:0] flags,
                            input logic [31:0] cntW, input logic [31:0] cntN);
    checkVal({tag, ".flagsW"}, 32'(busW.frameCollisions), 32'(flags));
    checkVal({tag, ".cntW"},   32'(busW.frameCollisionCount), cntW);
    checkVal({tag, ".flagsN"}, 32'(busN.frameCollisions), 32'(flags));
    checkVal({tag, ".cntN"},   32'(busN.frameCollisionCount), cntN);
  endtask

  initial begin
    layersRGB   = {8'h55, 8'hE0, 8'h1C, 8'h03};
    layerEnable = 4'b1111;
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    checkPixel("reset", 8'hFF, 1'b0, 2'd0, 1'b0);
    checkFrame("reset", 4'b0000, 0, 0);

    step(1'b0, 4'b0110, 1'b0);
    checkPixel("prio", 8'h1C, 1'b1, 2'd1, 1'b1);

    layerEnable = 4'b1101;
    step(1'b0, 4'b0110, 1'b0);
    checkPixel("disabled", 8'hE0, 1'b1, 2'd2, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    checkPixel("idle", 8'hFF, 1'b0, 2'd0, 1'b0);

    layerEnable = 4'b1111;
    step(1'b0, 4'b0000, 1'b1);
    checkFrame("sof0", 4'b0110, 1, 1);

    for (int i = 0; i < 5; i++) step(1'b0, 4'b1001, 1'b0);
    checkPixel("l0l3", 8'h03, 1'b1, 2'd0, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    checkFrame("sof1", 4'b1001, 5, 5);
    step(1'b0, 4'b0000, 1'b1);
    checkFrame("sof2", 4'b0000, 0, 0);

    step(1'b0, 4'b0011, 1'b1);
    checkFrame("sofColl", 4'b0000, 0, 0);
    checkPixel("sofColl", 8'h03, 1'b1, 2'd0, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    checkFrame("afterSofColl", 4'b0011, 1, 1);

    for (int i = 0; i < 20; i++) step(1'b0, 4'b1111, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    checkFrame("satur", 4'b1111, 20, 15);

    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    checkPixel("midReset", 8'hFF, 1'b0, 2'd0, 1'b0);
    checkFrame("midReset", 4'b0000, 0, 0);
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    checkFrame("postReset", 4'b0011, 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
